serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial W-bit adder that sequences the team's 3-input bit-sum (full-adder) stage over time.
- Operand and carry state live in registers.
- Each clock presents one (A, B, carry) triple to the bit-sum logic and captures the resulting sum bit and carry-out.
- Sits between the operand source and the datapath that consumes the W-bit result.

Parameters:
W, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
start  input  1  request pulse; operands sampled on the edge where start=1 and the block is accepting.
a  input  W  operand A; sampled with start only.
b  input  W  operand B; sampled with start only.
cin  input  1  carry-in; sampled with start only.
busy  output  1  high while bits are being processed.
done  output  1  single-cycle pulse; sum/cout valid from this cycle on.
sum  output  W  result (a + b + cin) mod 2^W; holds until the next completion.
cout  output  1  carry-out of bit W-1; holds with sum.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry FF and bit counter cleared.
  - An in-flight operation is abandoned.
  - No done is produced for the abandoned operation.
- States:
  - IDLE: accepting.
  - SHIFT: busy=1, not accepting.
  - DONE: done=1, accepting.
- IDLE/DONE, start=1 at edge k:
  - ra<=a, rb<=b, carry<=cin, cnt<=0, state<=SHIFT.
  - With start=0: DONE->IDLE, IDLE stays IDLE.
- SHIFT, each edge:
  - s = ra[0]^rb[0]^carry.
  - c = majority(ra[0], rb[0], carry).
  - ra, rb shift right (zero fill).
  - acc <= {s, acc[W-1:1]}, carry <= c, cnt <= cnt+1.
- SHIFT, edge with cnt==W-1 (the W-th shift):
  - sum <= {s, acc[W-1:1]}, cout <= c, state <= DONE.
- Latency:
  - Start captured at edge k.
  - busy high for cycles following edges k..k+W-1.
  - done high for exactly one cycle, following edge k+W.
  - sum/cout change only at edge k+W.
- start while in SHIFT is ignored. It is not queued, and the operands are not resampled.
- start in the DONE cycle is accepted (back-to-back).
  - This gives a throughput of one result per W+1 cycles.
  - The previous sum/cout stay held until the new completion.
- Width rules:
  - cnt is $clog2(W)+1 bits wide and never wraps past W-1.
  - W=1 gives a single SHIFT cycle.
- Outputs busy/done are decoded from registered state only; they have no combinational path from inputs.

Decomposition:
- Package serial_adder_pkg:
  - typedef enum logic [1:0] {SA_IDLE, SA_SHIFT, SA_DONE} sa_state_t.
  - localparam SA_MAX_W = 32.
- One sub-module, sa_bit_cell: a purely combinational 1-bit sum/carry cell (inputs x, y, ci; outputs s, co), instantiated once.
- FSM, shift registers and counter stay in serial_adder.

Test Plan:
1. W=8, a=0x5A, b=0x3C, cin=0, start at edge k -> busy high 8 cycles, done pulse after edge k+8, sum=0x96, cout=0.
2. W=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. Start 0x10+0x20, then pulse start with a=0xAA, b=0x55 at cycle 3 while busy -> ignored; result sum=0x30, cout=0, exactly one done.
4. Reset asserted asynchronously mid-SHIFT (cycle 4, between edges) -> immediately busy=0, done=0, sum=0, cout=0; no done follows; a fresh op 0x01+0x01 then yields sum=0x02.
5. Back-to-back: start held high through the DONE cycle of op 0x0F+0x01 with new a=0x80, b=0x80 -> first sum=0x10, cout=0; second done exactly 9 cycles after the first, sum=0x00, cout=1.
6. W=1: a=1, b=1, cin=1 -> done one cycle after the start edge; sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_SHIFT = 2'd1,
    SA_DONE  = 2'd2
  } sa_state_t;

  localparam int SA_MAX_W = 32;

endpackage

// File: rtl/sa_bit_cell.sv
// Combinational 1-bit sum/carry cell; the datapath that the serial adder
// steps over time, one bit position per clock.
module sa_bit_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one bit per clock, done pulses W+1 cycles after an
// accepted start; sum/cout hold until the next completion.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  import serial_adder_pkg::*;

  localparam int            CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  sa_state_t     r_state;
  logic [W-1:0]  r_ra;
  logic [W-1:0]  r_rb;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_sum;
  logic          r_cout;

  logic          w_s;
  logic          w_c;
  logic [W-1:0]  w_sum_next;

  sa_bit_cell u_cell (
    .x  (r_ra[0]),
    .y  (r_rb[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_c)
  );

  // The accumulator only needs W-1 bits: the final bit goes straight to sum.
  generate
    if (W == 1) begin : g_w1
      assign w_sum_next = w_s;
    end else begin : g_wn
      logic [W-2:0] r_acc;

      assign w_sum_next = {w_s, r_acc};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_acc <= '0;
        end else if (r_state == SA_SHIFT) begin
          r_acc <= w_sum_next[W-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SA_IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        SA_IDLE, SA_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ra    <= a;
            r_rb    <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SA_SHIFT;
          end else begin
            r_state <= SA_IDLE;
          end
        end
        SA_SHIFT: begin
          r_ra    <= r_ra >> 1;
          r_rb    <= r_rb >> 1;
          r_carry <= w_c;
          // Counter parks at LAST so it never wraps; reload happens on start.
          if (r_cnt == LAST) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= SA_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= SA_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at W=8 and W=1 against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           k;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic busy1, done1, sum1, cout1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done = 0;
  exp_t q[$];
  exp_t q1[$];

  serial_adder #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Monitors: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_done: got done with sum=%h cout=%b, expected no done", sum, cout);
      end else begin
        e = q.pop_front();
        if (sum !== e.s || cout !== e.c || cyc != e.k + W) begin
          n_err++;
          $display("FAIL result: got sum=%h cout=%b at cycle %0d, expected sum=%h cout=%b at cycle %0d",
                   sum, cout, cyc, e.s, e.c, e.k + W);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      n_chk++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL w1_spurious_done: got done, expected none");
      end else begin
        e = q1.pop_front();
        if (sum1 !== e.s[0] || cout1 !== e.c || cyc != e.k + 1) begin
          n_err++;
          $display("FAIL w1_result: got sum=%b cout=%b at cycle %0d, expected sum=%b cout=%b at cycle %0d",
                   sum1, cout1, cyc, e.s[0], e.c, e.k + 1);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int k);
    exp_t e;
    logic [W:0] t;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s = t[W-1:0];
    e.c = t[W];
    e.k = k;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge where done is expected.
  // poke >= 0 pulses a bogus start at that SHIFT cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input int poke);
    bit ok = 1;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    q.push_back(model(ta, tb_v, tc, cyc + 1));
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) ok = 0;
      if (i == poke) begin
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (!ok || done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_done_window: got busy_ok=%b done=%b busy=%b, expected busy_ok=1 done=1 busy=0",
               ok, done, busy);
      for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    end
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b sum=%h cout=%b (w1 %b%b%b%b), expected all zero",
               name, busy, done, sum, cout, busy1, done1, sum1, cout1);
    end
  endtask

  initial begin
    int d0, t1, gap;
    logic [W-1:0] ra, rb;

    #1 check_zero("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, -1);
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, -1);
    @(negedge clk);
    run_op(8'hFF, 8'hFF, 1'b1, -1);
    @(negedge clk);

    // Start while busy is ignored: one done, original operands.
    d0 = n_done;
    run_op(8'h10, 8'h20, 1'b0, 2);
    repeat (W + 3) @(negedge clk);
    n_chk++;
    if (n_done - d0 != 1) begin
      n_err++;
      $display("FAIL ignored_start: got %0d dones, expected 1", n_done - d0);
    end

    // Async reset mid-shift abandons the operation.
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    q.push_back(model(8'h33, 8'h44, 1'b0, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    q.delete();
    d0 = n_done;
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    n_chk++;
    if (n_done != d0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abandoned_op: got %0d dones busy=%b, expected 0 dones busy=0", n_done - d0, busy);
    end
    run_op(8'h01, 8'h01, 1'b0, -1);
    @(negedge clk);

    // Back-to-back: second start raised in the done cycle.
    run_op(8'h0F, 8'h01, 1'b0, -1);
    t1 = cyc;
    run_op(8'h80, 8'h80, 1'b0, -1);
    n_chk++;
    if (cyc - t1 != W + 1 || done !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back: got spacing %0d done=%b, expected spacing %0d done=1", cyc - t1, done, W + 1);
    end

    // Randomized traffic with random idle gaps (0 = back-to-back).
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom), -1);
    end
    @(negedge clk);

    // W=1 instance: all eight input combinations.
    for (int n = 0; n < 8; n++) begin
      exp_t e;
      logic [2:0] v;
      v = 3'(n);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      e.s = '0;
      e.s[0] = v[2] ^ v[1] ^ v[0];
      e.c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      e.k = cyc + 1;
      q1.push_back(e);
      @(negedge clk);
      start1 = 1'b0;
      n_chk++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_err++;
        $display("FAIL w1_busy: got busy=%b done=%b, expected busy=1 done=0", busy1, done1);
      end
      @(negedge clk);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL outstanding: got %0d/%0d pending results, expected 0/0", q.size(), q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
